vector_lsu: RTL and testbench

Vector load/store unit that sits directly upstream of data_mem. It accepts one vector memory command (base, stride, length, bank, vector register) and sequences it into single-element data_mem accesses over the start/rw/addr/bank_select/din handshake. Read data (dout) is returned to the vector register file. It supports one outstanding memory access and one command at a time.

---
 rtl/vector_lsu_if.sv | 61 ++++++
 rtl/vector_lsu.sv | 147 ++++++++++++++
 tb/tb_vector_lsu.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_lsu_if.sv
// Bundle between the vector load/store unit and its surroundings:
// command channel, vector register file ports and the data_mem handshake.
interface vector_lsu_if #(
    parameter int DW = 32,
    parameter int AW = 6,
    parameter int BW = 3,
    parameter int IW = 3
);
    // command channel
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_load;
    logic [AW-1:0] cmd_base;
    logic [AW-1:0] cmd_stride;
    logic [IW:0]   cmd_len;
    logic [BW-1:0] cmd_bank;
    logic [2:0]    cmd_vreg;
    logic          busy;
    logic          cmd_done;

    // vector register file
    logic [2:0]    vrf_rd_reg;
    logic [IW-1:0] vrf_rd_idx;
    logic [DW-1:0] vrf_rd_data;
    logic          vrf_wr_en;
    logic [2:0]    vrf_wr_reg;
    logic [IW-1:0] vrf_wr_idx;
    logic [DW-1:0] vrf_wr_data;

    // data_mem handshake
    logic          mem_start;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_bank;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          mem_ready;
    logic          mem_done;

    // LSU side
    modport master (
        input  cmd_valid, cmd_load, cmd_base, cmd_stride, cmd_len, cmd_bank, cmd_vreg,
        output cmd_ready, busy, cmd_done,
        output vrf_rd_reg, vrf_rd_idx,
        input  vrf_rd_data,
        output vrf_wr_en, vrf_wr_reg, vrf_wr_idx, vrf_wr_data,
        output mem_start, mem_rw, mem_addr, mem_bank, mem_din,
        input  mem_dout, mem_ready, mem_done
    );

    // environment side (command source, VRF and data_mem)
    modport slave (
        output cmd_valid, cmd_load, cmd_base, cmd_stride, cmd_len, cmd_bank, cmd_vreg,
        input  cmd_ready, busy, cmd_done,
        input  vrf_rd_reg, vrf_rd_idx,
        output vrf_rd_data,
        input  vrf_wr_en, vrf_wr_reg, vrf_wr_idx, vrf_wr_data,
        input  mem_start, mem_rw, mem_addr, mem_bank, mem_din,
        output mem_dout, mem_ready, mem_done
    );
endinterface

// File: rtl/vector_lsu.sv
// Vector load/store unit: turns one strided vector command into a sequence
// of single-element data_mem accesses, one access outstanding at a time.
module vector_lsu #(
    parameter int DW   = 32,
    parameter int AW   = 6,
    parameter int BW   = 3,
    parameter int VLEN = 8,
    parameter int IW   = 3
) (
    input  logic         clk,
    input  logic         reset,
    vector_lsu_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

    localparam logic [IW:0] VLEN_C = (IW + 1)'(VLEN);

    state_t        state_reg;
    logic          load_reg;
    logic [AW-1:0] addr_reg;
    logic [AW-1:0] stride_reg;
    logic [IW:0]   len_reg;
    logic [BW-1:0] bank_reg;
    logic [2:0]    vreg_reg;
    logic [IW-1:0] idx_reg;

    logic          busy_reg;
    logic          cmd_done_reg;
    logic          vrf_wr_en_reg;
    logic [2:0]    wr_vreg_reg;
    logic [IW-1:0] wr_idx_reg;
    logic [DW-1:0] wr_data_reg;
    logic          mem_start_reg;
    logic          mem_rw_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [BW-1:0] mem_bank_reg;
    logic [DW-1:0] mem_din_reg;

    logic [IW:0]   len_clamped;
    logic [IW:0]   idx_inc;

    // Oversized lengths are treated as a full vector.
    assign len_clamped = (bus.cmd_len > VLEN_C) ? VLEN_C : bus.cmd_len;
    // Element count after the current access completes, compared against len.
    assign idx_inc     = {1'b0, idx_reg} + {{IW{1'b0}}, 1'b1};

    assign bus.cmd_ready   = (state_reg == IDLE);
    assign bus.busy        = busy_reg;
    assign bus.cmd_done    = cmd_done_reg;
    assign bus.vrf_rd_reg  = vreg_reg;
    assign bus.vrf_rd_idx  = idx_reg;
    assign bus.vrf_wr_en   = vrf_wr_en_reg;
    assign bus.vrf_wr_reg  = wr_vreg_reg;
    assign bus.vrf_wr_idx  = wr_idx_reg;
    assign bus.vrf_wr_data = wr_data_reg;
    assign bus.mem_start   = mem_start_reg;
    assign bus.mem_rw      = mem_rw_reg;
    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_bank    = mem_bank_reg;
    assign bus.mem_din     = mem_din_reg;

    // Command sequencer: accept, issue each element, wait for completion, signal done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            load_reg      <= 1'b0;
            addr_reg      <= '0;
            stride_reg    <= '0;
            len_reg       <= '0;
            bank_reg      <= '0;
            vreg_reg      <= '0;
            idx_reg       <= '0;
            busy_reg      <= 1'b0;
            cmd_done_reg  <= 1'b0;
            vrf_wr_en_reg <= 1'b0;
            wr_vreg_reg   <= '0;
            wr_idx_reg    <= '0;
            wr_data_reg   <= '0;
            mem_start_reg <= 1'b0;
            mem_rw_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_bank_reg  <= '0;
            mem_din_reg   <= '0;
        end else begin
            // strobes are single-cycle unless re-asserted below
            vrf_wr_en_reg <= 1'b0;
            mem_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        load_reg   <= bus.cmd_load;
                        addr_reg   <= bus.cmd_base;
                        stride_reg <= bus.cmd_stride;
                        len_reg    <= len_clamped;
                        bank_reg   <= bus.cmd_bank;
                        vreg_reg   <= bus.cmd_vreg;
                        idx_reg    <= '0;
                        busy_reg   <= 1'b1;
                        if (len_clamped == '0) begin
                            // empty vector: complete without touching memory
                            cmd_done_reg <= 1'b1;
                            state_reg    <= FIN;
                        end else begin
                            state_reg <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        // address/bank/rw/din stay on the bus until the next issue
                        mem_start_reg <= 1'b1;
                        mem_addr_reg  <= addr_reg;
                        mem_bank_reg  <= bank_reg;
                        mem_rw_reg    <= ~load_reg;
                        mem_din_reg   <= load_reg ? '0 : bus.vrf_rd_data;
                        state_reg     <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_done) begin
                        if (load_reg) begin
                            vrf_wr_en_reg <= 1'b1;
                            wr_vreg_reg   <= vreg_reg;
                            wr_idx_reg    <= idx_reg;
                            wr_data_reg   <= bus.mem_dout;
                        end
                        idx_reg  <= idx_reg + 1'b1;
                        // address wraps silently at the top of the bank
                        addr_reg <= addr_reg + stride_reg;
                        if (idx_inc == len_reg) begin
                            cmd_done_reg <= 1'b1;
                            state_reg    <= FIN;
                        end else begin
                            state_reg <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    cmd_done_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_lsu.sv
// Bench for vector_lsu: behavioural data_mem and VRF around the unit,
// expected accesses and VRF writes queued as commands are sent.
module tb_vector_lsu;
    localparam int DW = 32, AW = 6, BW = 3, VLEN = 8, IW = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vector_lsu_if #(.DW(DW), .AW(AW), .BW(BW), .IW(IW)) bus_if ();

    vector_lsu #(.DW(DW), .AW(AW), .BW(BW), .VLEN(VLEN), .IW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [BW-1:0] bank;
        logic [DW-1:0] din;
    } mem_exp_t;

    typedef struct {
        logic [2:0]    vreg;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
    } wr_exp_t;

    mem_exp_t exp_mem_q[$];
    wr_exp_t  exp_wr_q[$];

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int start_cnt = 0;

    logic [DW-1:0] vrf  [8][VLEN];
    logic [DW-1:0] dmem [8][64];   // contents seen by the responder
    logic [DW-1:0] gmem [8][64];   // bench-side golden contents

    logic          resp_en = 1'b1;
    int            mem_lat = 1;
    logic          resp_done = 1'b0;
    logic          stray_done = 1'b0;
    logic [DW-1:0] resp_dout = '0;

    assign bus_if.vrf_rd_data = vrf[bus_if.vrf_rd_reg][bus_if.vrf_rd_idx];
    assign bus_if.mem_done    = resp_done | stray_done;
    assign bus_if.mem_dout    = resp_dout;

    // data_mem responder: completes each started access after mem_lat cycles
    initial begin
        logic          rw;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (resp_en && reset && bus_if.mem_start) begin
                rw = bus_if.mem_rw;
                a  = bus_if.mem_addr;
                b  = bus_if.mem_bank;
                d  = bus_if.mem_din;
                for (int k = 1; k < mem_lat; k++) @(negedge clk);
                if (rw) dmem[b][a] = d;
                else    resp_dout = dmem[b][a];
                resp_done = 1'b1;
            end
        end
    end

    // monitor: pops scoreboard entries as accesses and VRF writes appear
    initial begin
        mem_exp_t em;
        wr_exp_t  ew;
        logic     prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_start = 1'b0;
            end else begin
                if (bus_if.mem_start) begin
                    start_cnt++;
                    vectors++;
                    if (prev_start) begin
                        miscompares++;
                        $display("FAIL start_width: mem_start high 2+ cycles, required 1-cycle pulse");
                    end
                    vectors++;
                    if (exp_mem_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL mem_access: unexpected start rw=%0d addr=%0d bank=%0d din=%0d, required none",
                                 bus_if.mem_rw, bus_if.mem_addr, bus_if.mem_bank, bus_if.mem_din);
                    end else begin
                        em = exp_mem_q.pop_front();
                        if ({bus_if.mem_rw, bus_if.mem_addr, bus_if.mem_bank, bus_if.mem_din} !==
                            {em.rw, em.addr, em.bank, em.din}) begin
                            miscompares++;
                            $display("FAIL mem_access: got rw=%0d addr=%0d bank=%0d din=%0d, required rw=%0d addr=%0d bank=%0d din=%0d",
                                     bus_if.mem_rw, bus_if.mem_addr, bus_if.mem_bank, bus_if.mem_din,
                                     em.rw, em.addr, em.bank, em.din);
                        end
                    end
                end
                if (bus_if.vrf_wr_en) begin
                    vectors++;
                    if (exp_wr_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL vrf_write: unexpected write reg=%0d idx=%0d data=%0d, required none",
                                 bus_if.vrf_wr_reg, bus_if.vrf_wr_idx, bus_if.vrf_wr_data);
                    end else begin
                        ew = exp_wr_q.pop_front();
                        if ({bus_if.vrf_wr_reg, bus_if.vrf_wr_idx, bus_if.vrf_wr_data} !==
                            {ew.vreg, ew.idx, ew.data}) begin
                            miscompares++;
                            $display("FAIL vrf_write: got reg=%0d idx=%0d data=%0d, required reg=%0d idx=%0d data=%0d",
                                     bus_if.vrf_wr_reg, bus_if.vrf_wr_idx, bus_if.vrf_wr_data,
                                     ew.vreg, ew.idx, ew.data);
                        end
                    end
                end
                if (bus_if.cmd_done) done_cnt++;
                prev_start = bus_if.mem_start;
            end
        end
    end

    // queue the expected element traffic, then present the command until accepted
    task automatic send_cmd(input logic load, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                            input logic [IW:0] len, input logic [BW-1:0] bank, input logic [2:0] vreg);
        int            n;
        int            t;
        logic [AW-1:0] a;
        n = (int'(len) > VLEN) ? VLEN : int'(len);
        a = base;
        for (int i = 0; i < n; i++) begin
            if (load) begin
                exp_mem_q.push_back('{rw: 1'b0, addr: a, bank: bank, din: '0});
                exp_wr_q.push_back('{vreg: vreg, idx: IW'(i), data: gmem[bank][a]});
            end else begin
                exp_mem_q.push_back('{rw: 1'b1, addr: a, bank: bank, din: vrf[vreg][i]});
                gmem[bank][a] = vrf[vreg][i];
            end
            a = a + stride;
        end
        @(negedge clk);
        bus_if.cmd_valid  = 1'b1;
        bus_if.cmd_load   = load;
        bus_if.cmd_base   = base;
        bus_if.cmd_stride = stride;
        bus_if.cmd_len    = len;
        bus_if.cmd_bank   = bank;
        bus_if.cmd_vreg   = vreg;
        t = 0;
        while (!bus_if.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (!bus_if.cmd_ready) begin
            miscompares++;
            $display("FAIL cmd_accept: cmd_ready=0 after 200 cycles, required 1");
        end
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
    endtask

    // wait for cmd_done, check busy/ready around it and that the scoreboard drained
    task automatic wait_done(input string name, input int budget, input logic last_wr);
        int t;
        t = 0;
        while (!bus_if.cmd_done && t < budget) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (!bus_if.cmd_done) begin
            miscompares++;
            $display("FAIL %s done_timeout: cmd_done=0 after %0d cycles, required 1", name, budget);
        end else begin
            vectors++;
            if ({bus_if.busy, bus_if.cmd_ready} !== 2'b10) begin
                miscompares++;
                $display("FAIL %s done_cycle: busy,ready=%b, required 10", name, {bus_if.busy, bus_if.cmd_ready});
            end
            if (last_wr) begin
                vectors++;
                if (bus_if.vrf_wr_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s last_wr: vrf_wr_en=%b in done cycle, required 1", name, bus_if.vrf_wr_en);
                end
            end
            @(negedge clk);
            vectors++;
            if ({bus_if.cmd_done, bus_if.busy, bus_if.cmd_ready} !== 3'b001) begin
                miscompares++;
                $display("FAIL %s after_done: done,busy,ready=%b, required 001", name,
                         {bus_if.cmd_done, bus_if.busy, bus_if.cmd_ready});
            end
        end
        vectors++;
        if (exp_mem_q.size() != 0 || exp_wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s leftover: %0d accesses and %0d writes outstanding, required 0 and 0",
                     name, exp_mem_q.size(), exp_wr_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus_if.cmd_ready, bus_if.busy, bus_if.cmd_done, bus_if.mem_start, bus_if.mem_rw, bus_if.vrf_wr_en} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready,busy,done,start,rw,wr_en=%b, required 100000",
                     {bus_if.cmd_ready, bus_if.busy, bus_if.cmd_done, bus_if.mem_start, bus_if.mem_rw, bus_if.vrf_wr_en});
        end
        vectors++;
        if ({bus_if.mem_addr, bus_if.mem_bank, bus_if.mem_din} !== '0) begin
            miscompares++;
            $display("FAIL reset_membus: addr=%0d bank=%0d din=%0d, required 0 0 0",
                     bus_if.mem_addr, bus_if.mem_bank, bus_if.mem_din);
        end
        vectors++;
        if ({bus_if.vrf_rd_reg, bus_if.vrf_rd_idx, bus_if.vrf_wr_reg, bus_if.vrf_wr_idx, bus_if.vrf_wr_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_vrf: rd_reg=%0d rd_idx=%0d wr_reg=%0d wr_idx=%0d wr_data=%0d, required all 0",
                     bus_if.vrf_rd_reg, bus_if.vrf_rd_idx, bus_if.vrf_wr_reg, bus_if.vrf_wr_idx, bus_if.vrf_wr_data);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_if.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: cmd_ready=%b, required 1", bus_if.cmd_ready);
        end
    endtask

    task automatic test_store();
        int d0, s0;
        d0 = done_cnt; s0 = start_cnt;
        send_cmd(1'b0, 6'd0, 6'd1, 4'd2, 3'd1, 3'd2);
        wait_done("store", 50, 1'b0);
        vectors++;
        if (done_cnt - d0 != 1 || start_cnt - s0 != 2) begin
            miscompares++;
            $display("FAIL store_counts: dones=%0d starts=%0d, required 1 and 2", done_cnt - d0, start_cnt - s0);
        end
    endtask

    task automatic test_load();
        int d0, s0;
        d0 = done_cnt; s0 = start_cnt;
        send_cmd(1'b1, 6'd0, 6'd1, 4'd2, 3'd1, 3'd5);
        wait_done("load", 50, 1'b1);
        vectors++;
        if (done_cnt - d0 != 1 || start_cnt - s0 != 2) begin
            miscompares++;
            $display("FAIL load_counts: dones=%0d starts=%0d, required 1 and 2", done_cnt - d0, start_cnt - s0);
        end
    endtask

    task automatic test_wrap();
        dmem[3][62] = 32'h1111_0062; gmem[3][62] = 32'h1111_0062;
        dmem[3][63] = 32'h2222_0063; gmem[3][63] = 32'h2222_0063;
        dmem[3][0]  = 32'h3333_0000; gmem[3][0]  = 32'h3333_0000;
        send_cmd(1'b1, 6'd62, 6'd1, 4'd3, 3'd3, 3'd1);
        wait_done("wrap", 60, 1'b1);
    endtask

    task automatic test_ready_stall();
        logic [AW-1:0] a0;
        logic [BW-1:0] b0;
        logic          r0;
        bus_if.mem_ready = 1'b0;
        send_cmd(1'b0, 6'd5, 6'd0, 4'd1, 3'd2, 3'd2);
        a0 = bus_if.mem_addr; b0 = bus_if.mem_bank; r0 = bus_if.mem_rw;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (bus_if.mem_start !== 1'b0 || {bus_if.mem_addr, bus_if.mem_bank, bus_if.mem_rw} !== {a0, b0, r0}) begin
                miscompares++;
                $display("FAIL stall_hold: start=%b addr=%0d bank=%0d rw=%0d, required 0 %0d %0d %0d",
                         bus_if.mem_start, bus_if.mem_addr, bus_if.mem_bank, bus_if.mem_rw, a0, b0, r0);
            end
            @(negedge clk);
        end
        bus_if.mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus_if.mem_start !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: mem_start=%b one cycle after ready, required 1", bus_if.mem_start);
        end
        wait_done("stall", 30, 1'b0);
    endtask

    task automatic test_len_zero();
        int d0, s0;
        d0 = done_cnt; s0 = start_cnt;
        send_cmd(1'b0, 6'd7, 6'd1, 4'd0, 3'd0, 3'd0);
        // cycle after the accepting edge: the FIN cycle
        vectors++;
        if (bus_if.cmd_done !== 1'b1) begin
            miscompares++;
            $display("FAIL len0_latency: cmd_done=%b after accept, required 1", bus_if.cmd_done);
        end
        wait_done("len0", 5, 1'b0);
        vectors++;
        if (done_cnt - d0 != 1 || start_cnt - s0 != 0) begin
            miscompares++;
            $display("FAIL len0_counts: dones=%0d starts=%0d, required 1 and 0", done_cnt - d0, start_cnt - s0);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        resp_en = 1'b0;
        send_cmd(1'b1, 6'd0, 6'd1, 4'd2, 3'd1, 3'd3);
        t = 0;
        while (!bus_if.mem_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (!bus_if.mem_start) begin
            miscompares++;
            $display("FAIL rstmid_start: mem_start=0 after 20 cycles, required 1");
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({bus_if.cmd_ready, bus_if.busy, bus_if.cmd_done, bus_if.mem_start, bus_if.vrf_wr_en, bus_if.mem_rw} !== 6'b100000 ||
            bus_if.mem_addr !== '0 || bus_if.mem_bank !== '0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: ready,busy,done,start,wr_en,rw=%b addr=%0d bank=%0d, required 100000 0 0",
                     {bus_if.cmd_ready, bus_if.busy, bus_if.cmd_done, bus_if.mem_start, bus_if.vrf_wr_en, bus_if.mem_rw},
                     bus_if.mem_addr, bus_if.mem_bank);
        end
        exp_mem_q.delete();
        exp_wr_q.delete();
        @(negedge clk);
        reset = 1'b1;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (bus_if.vrf_wr_en !== 1'b0 || bus_if.cmd_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL rstmid_stray: vrf_wr_en=%b cmd_ready=%b after stray mem_done, required 0 1",
                         bus_if.vrf_wr_en, bus_if.cmd_ready);
            end
            @(negedge clk);
        end
        resp_en = 1'b1;
        send_cmd(1'b0, 6'd20, 6'd2, 4'd2, 3'd5, 3'd2);
        wait_done("rstmid_next", 40, 1'b0);
    endtask

    task automatic test_back_to_back();
        int d0, s0;
        d0 = done_cnt; s0 = start_cnt;
        mem_lat = 3;
        // oversized length clamps to VLEN; second command is held while busy
        send_cmd(1'b0, 6'd10, 6'd3, 4'd15, 3'd4, 3'd6);
        send_cmd(1'b1, 6'd13, 6'd0, 4'd3, 3'd4, 3'd7);
        wait_done("b2b", 100, 1'b1);
        vectors++;
        if (done_cnt - d0 != 2 || start_cnt - s0 != 11) begin
            miscompares++;
            $display("FAIL b2b_counts: dones=%0d starts=%0d, required 2 and 11", done_cnt - d0, start_cnt - s0);
        end
        mem_lat = 1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < VLEN; i++) vrf[r][i] = '0;
            for (int a = 0; a < 64; a++) begin
                dmem[r][a] = '0;
                gmem[r][a] = '0;
            end
        end
        vrf[2][0] = 32'd45;
        vrf[2][1] = 32'd50;
        for (int i = 0; i < VLEN; i++) vrf[6][i] = 32'hA000_0000 + 32'(i * 7 + 1);
        bus_if.cmd_valid  = 1'b0;
        bus_if.cmd_load   = 1'b0;
        bus_if.cmd_base   = '0;
        bus_if.cmd_stride = '0;
        bus_if.cmd_len    = '0;
        bus_if.cmd_bank   = '0;
        bus_if.cmd_vreg   = '0;
        bus_if.mem_ready  = 1'b1;

        test_reset();
        test_store();
        test_load();
        test_wrap();
        test_ready_stall();
        test_len_zero();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
